// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: configuration-chain controller for routing tiles.
// Takes a packed bitstream as DATA_W-bit words over valid/ready and shifts
// exactly CHAIN_LEN bits onto the tile's ccff_head, MSB of each word first,
// qualifying every bit with cfg_shift_en. Pulses done after the last bit.
//
// Optional feature (macro CCFF_READBACK_EN): CRC-16-CCITT (poly 0x1021,
// MSB-first, init 0xFFFF on start, no final XOR) over the old configuration
// bits leaving the chain on ccff_tail. Without the macro readback_crc is
// tied to 16'hFFFF and ccff_tail is ignored.
//
// Ports:
//   prog_clk      programming clock, all state on the rising edge
//   pReset        synchronous active-high reset
//   start         load request pulse, honoured in IDLE or DONE only
//   in_data       bitstream word, bit DATA_W-1 shifted first
//   in_valid      in_data valid
//   in_ready      high in LOAD; word taken when in_valid && in_ready
//   ccff_head     serial configuration bit into the chain
//   cfg_shift_en  chain advances on this edge when high
//   ccff_tail     chain output (readback only)
//   busy          high in LOAD and SHIFT
//   done          one-cycle pulse after the last bit has been shifted
//   bits_left     bits still to shift in this load
//   readback_crc  CRC of bits that left the chain during the last load

module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 30,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              cfg_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left,
    output logic [15:0]       readback_crc
);

    // Width of the per-word bit counter, holds 0..DATA_W.
    localparam int unsigned SC_W = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [SC_W-1:0]   sreg_cnt;
    logic              start_ok;

    // A new load may only begin from IDLE or from the DONE pulse cycle.
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    // Control FSM, word register and bit counters.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= IDLE;
            sreg      <= '0;
            sreg_cnt  <= '0;
            bits_left <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bits_left <= CNT_W'(CHAIN_LEN);
                        sreg_cnt  <= '0;
                        state     <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        sreg     <= in_data;
                        sreg_cnt <= SC_W'(DATA_W);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg      <= sreg << 1;
                    sreg_cnt  <= sreg_cnt - SC_W'(1);
                    bits_left <= bits_left - CNT_W'(1);
                    // Chain full wins over word empty: leftover word bits are dropped.
                    if (bits_left == CNT_W'(1)) begin
                        state <= DONE;
                    end else if (sreg_cnt == SC_W'(1)) begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register directly, so they change only on edges.
    assign in_ready     = (state == LOAD);
    // The bits_left term keeps the enable low on a zero count even if the
    // state were ever corrupted into SHIFT.
    assign cfg_shift_en = (state == SHIFT) && (bits_left != '0);
    assign ccff_head    = cfg_shift_en && sreg[DATA_W-1];
    assign busy         = (state == LOAD) || (state == SHIFT);
    assign done         = (state == DONE);

`ifdef CCFF_READBACK_EN
    logic [15:0] crc;

    // One MSB-first CRC-16-CCITT step for a single input bit.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Fold each bit leaving the chain into the CRC; restart it on an accepted start.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            crc <= 16'hFFFF;
        end else if (start_ok) begin
            crc <= 16'hFFFF;
        end else if (cfg_shift_en) begin
            crc <= crc_step(crc, ccff_tail);
        end
    end

    assign readback_crc = crc;
`else
    logic unused_readback;

    assign unused_readback = ccff_tail ^ start_ok;
    assign readback_crc    = 16'hFFFF;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: default 30-bit/8-bit instance plus a
// 6-bit single-word instance. A 30-flop chain model is driven by the main
// instance so readback can be checked when CCFF_READBACK_EN is defined.

module tb_ccff_chain_loader;

    logic        clk = 1'b0;
    logic        pReset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ccff_head;
    logic        cfg_shift_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic [15:0] bits_left;
    logic [15:0] readback_crc;

    logic        start6;
    logic [7:0]  in_data6;
    logic        in_valid6;
    logic        in_ready6;
    logic        head6;
    logic        shift6;
    logic        tail6;
    logic        busy6;
    logic        done6;
    logic [15:0] bits_left6;
    logic [15:0] crc6;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [7:0]  words [4];
    logic [29:0] chain = '1;

    localparam logic [29:0] EXP_BITS = 30'b10100101_00111100_11110000_110000;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(30), .DATA_W(8), .CNT_W(16)) dut (
        .prog_clk(clk), .pReset(pReset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
        .cfg_shift_en(cfg_shift_en), .ccff_tail(ccff_tail), .busy(busy),
        .done(done), .bits_left(bits_left), .readback_crc(readback_crc)
    );

    ccff_chain_loader #(.CHAIN_LEN(6), .DATA_W(8), .CNT_W(16)) dut6 (
        .prog_clk(clk), .pReset(pReset), .start(start6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .ccff_head(head6),
        .cfg_shift_en(shift6), .ccff_tail(tail6), .busy(busy6),
        .done(done6), .bits_left(bits_left6), .readback_crc(crc6)
    );

    // Behavioural configuration chain; the first bit shifted in leaves first.
    always @(posedge clk) begin
        if (cfg_shift_en) chain <= {chain[28:0], ccff_head};
    end
    assign ccff_tail = chain[29];
    assign tail6     = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-16-CCITT over the n most recent bits of b, oldest first.
    function automatic logic [15:0] crc_bits(input logic [29:0] b, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // One load of the four-word stream: optional stall before a word, an
    // optional start pulse at bits_left==17, an optional reset at bits_left==10.
    task automatic run_load(input int stall_word, input int stall_len,
                            input bit inj_start, input bit inj_reset,
                            output int cycles, output logic [29:0] bits,
                            output int nbits, output int accepts, output int max_low);
        int widx;
        int stalled;
        int c;
        int low_run;
        bit seen_shift;
        bit pending16;
        widx = 0; stalled = 0; c = 0; low_run = 0;
        seen_shift = 0; pending16 = 0;
        cycles = -1; bits = '0; nbits = 0; accepts = 0; max_low = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (c < 200) begin
            if (inj_reset && bits_left == 16'd10) begin
                pReset = 1'b1;
                tick();
                pReset = 1'b0;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_shift_en", 32'(cfg_shift_en), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_bits_left", 32'(bits_left), 32'd0);
                tick();
                check("rst_idle_shift_en", 32'(cfg_shift_en), 32'd0);
                return;
            end
            if (widx == stall_word && in_ready && stalled < stall_len) begin
                in_valid = 1'b0;
                stalled++;
            end else begin
                in_valid = 1'b1;
            end
            in_data = (widx < 4) ? words[widx[1:0]] : 8'h00;
            if (inj_start && !pending16 && cfg_shift_en && bits_left == 16'd17) begin
                start     = 1'b1;
                pending16 = 1'b1;
            end
            if (cfg_shift_en) begin
                bits = {bits[28:0], ccff_head};
                nbits++;
                if (seen_shift && low_run > max_low) max_low = low_run;
                low_run    = 0;
                seen_shift = 1'b1;
            end else if (seen_shift) begin
                low_run++;
            end
            if (in_valid && in_ready) begin
                accepts++;
                widx++;
            end
            tick();
            c++;
            if (start) begin
                start = 1'b0;
                check("start_ignored_bits_left", 32'(bits_left), 32'd16);
            end
            if (done) begin
                cycles = c;
                break;
            end
        end
        in_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
    endtask

    initial begin
        int          cyc;
        int          nb;
        int          acc;
        int          mlow;
        int          extra;
        logic [29:0] bits;
        logic [29:0] first_bits;

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'hC3;
        pReset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        start6 = 1'b0; in_data6 = 8'h00; in_valid6 = 1'b0;

        // Reset state.
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_head", 32'(ccff_head), 32'd0);
        check("reset_shift_en", 32'(cfg_shift_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bits_left", 32'(bits_left), 32'd0);
        check("reset_crc", 32'(readback_crc), 32'h0000FFFF);
        pReset = 1'b0;
        tick();

        // Plain load, words always valid; chain model holds all ones beforehand.
        run_load(-1, 0, 1'b0, 1'b0, cyc, bits, nb, acc, mlow);
        check("plain_cycles", 32'(cyc), 32'd34);
        check("plain_nbits", 32'(nb), 32'd30);
        check("plain_bits", 32'(bits), 32'(EXP_BITS));
        check("plain_accepts", 32'(acc), 32'd4);
        check("plain_bubble", 32'(mlow), 32'd1);
        check("plain_bits_left", 32'(bits_left), 32'd0);
        check("plain_busy_at_done", 32'(busy), 32'd0);
`ifdef CCFF_READBACK_EN
        check("crc_load1", 32'(readback_crc), 32'(crc_bits(30'h3FFFFFFF, 30)));
`else
        check("crc_tied_1", 32'(readback_crc), 32'h0000FFFF);
`endif
        first_bits = bits;

        // Restart from the DONE cycle with a 5-cycle stall before word 3.
        run_load(2, 5, 1'b0, 1'b0, cyc, bits, nb, acc, mlow);
        check("stall_cycles", 32'(cyc), 32'd39);
        check("stall_low_run", 32'(mlow), 32'd6);
        check("stall_bits", 32'(bits), 32'(EXP_BITS));
        check("stall_nbits", 32'(nb), 32'd30);
`ifdef CCFF_READBACK_EN
        check("crc_load2", 32'(readback_crc), 32'(crc_bits(first_bits, 30)));
`else
        check("crc_tied_2", 32'(readback_crc), 32'h0000FFFF);
`endif
        tick();
        check("stall_done_one_cycle", 32'(done), 32'd0);
        check("stall_idle_in_ready", 32'(in_ready), 32'd0);
        check("stall_idle_busy", 32'(busy), 32'd0);
        tick();

        // Start pulse in mid-SHIFT must be ignored.
        run_load(-1, 0, 1'b1, 1'b0, cyc, bits, nb, acc, mlow);
        check("midstart_cycles", 32'(cyc), 32'd34);
        check("midstart_bits", 32'(bits), 32'(EXP_BITS));
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) extra++;
        end
        check("midstart_single_done", 32'(extra), 32'd0);

        // Reset at bits_left==10, then a full reload.
        run_load(-1, 0, 1'b0, 1'b1, cyc, bits, nb, acc, mlow);
        run_load(-1, 0, 1'b0, 1'b0, cyc, bits, nb, acc, mlow);
        check("reload_cycles", 32'(cyc), 32'd34);
        check("reload_nbits", 32'(nb), 32'd30);
        check("reload_bits", 32'(bits), 32'(EXP_BITS));
        tick();

        // Six-bit chain, single all-ones word, in_valid held high throughout.
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        check("c6_in_ready", 32'(in_ready6), 32'd1);
        check("c6_busy", 32'(busy6), 32'd1);
        in_valid6 = 1'b1;
        in_data6  = 8'hFF;
        tick();
        check("c6_bits_left", 32'(bits_left6), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("c6_shift_en", 32'(shift6), 32'd1);
            check("c6_head", 32'(head6), 32'd1);
            check("c6_no_ready", 32'(in_ready6), 32'd0);
            tick();
        end
        check("c6_done", 32'(done6), 32'd1);
        check("c6_bits_left_end", 32'(bits_left6), 32'd0);
        check("c6_ready_at_done", 32'(in_ready6), 32'd0);
`ifdef CCFF_READBACK_EN
        check("c6_crc", 32'(crc6), 32'(crc_bits(30'h0, 6)));
`else
        check("c6_crc", 32'(crc6), 32'h0000FFFF);
`endif
        tick();
        check("c6_done_one_cycle", 32'(done6), 32'd0);
        check("c6_idle_shift_en", 32'(shift6), 32'd0);
        in_valid6 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
